hart_mem_arbiter: RTL and testbench

HART_MEM_ARBITER -- requirements
Module: hart_mem_arbiter

---
 rtl/hart_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_hart_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hart_mem_arbiter.sv
`default_nettype none
// ============================================================================
// hart_mem_arbiter -- round-robin, lock-aware arbiter from NHART hart ports
// onto a single memory-controller command port.                   Rev 1.0
// ============================================================================
module hart_mem_arbiter #(
  parameter int NHART    = 2,
  parameter int LOCK_MAX = 4
) (
  input  logic                  CLK,
  input  logic                  RST_X,
  input  logic [NHART-1:0]      i_req,
  input  logic [NHART-1:0]      i_lock,
  input  logic [NHART-1:0]      i_we,
  input  logic [32*NHART-1:0]   i_addr,
  input  logic [32*NHART-1:0]   i_wdata,
  input  logic [3*NHART-1:0]    i_ctrl,
  output logic [NHART-1:0]      o_grant,
  output logic [NHART-1:0]      o_done,
  output logic [NHART-1:0]      o_stall,
  output logic [127:0]          o_rdata,
  output logic                  o_mc_req,
  output logic                  o_mc_we,
  output logic [31:0]           o_mc_addr,
  output logic [31:0]           o_mc_wdata,
  output logic [2:0]            o_mc_ctrl,
  input  logic                  i_mc_busy,
  input  logic [127:0]          i_mc_rdata
);

  localparam int               IW       = (NHART > 1) ? $clog2(NHART) : 1;
  localparam int               CW       = $clog2(LOCK_MAX + 1);
  localparam logic [IW-1:0]    LAST_RST = IW'(NHART - 1);
  localparam logic [CW-1:0]    LOCK_LIM = CW'(LOCK_MAX);
  localparam logic [NHART-1:0] ONE      = NHART'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [NHART-1:0]  grant_q, grant_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [IW-1:0]     last_q, last_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [127:0]      rdata_q, rdata_d;
  logic              lock_held_q, lock_held_d;
  logic [CW-1:0]     lock_cnt_q, lock_cnt_d;
  logic              wfirst_q, wfirst_d;

  logic [31:0]       w_addr  [NHART];
  logic [31:0]       w_wdata [NHART];
  logic [2:0]        w_ctrl  [NHART];

  for (genvar h = 0; h < NHART; h++) begin : g_unpack
    assign w_addr[h]  = i_addr[32*h +: 32];
    assign w_wdata[h] = i_wdata[32*h +: 32];
    assign w_ctrl[h]  = i_ctrl[3*h +: 3];
  end

  logic              w_lock_rel;
  logic [NHART-1:0]  w_req_eff;
  logic              w_pick_vld;
  logic [IW-1:0]     w_pick_idx;
  logic [IW-1:0]     w_cand;
  logic [CW-1:0]     w_cnt_inc;

  always_comb begin
    w_lock_rel = lock_held_q & ~i_lock[last_q];
    w_req_eff  = i_req;
    if (lock_held_q && !w_lock_rel) begin
      w_req_eff = i_req & (ONE << last_q);
    end
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_cand     = '0;
    // Farthest candidate first, so the nearest requester after last_q wins.
    for (int k = NHART; k >= 1; k--) begin
      w_cand = IW'((int'(last_q) + k) % NHART);
      if (w_req_eff[w_cand]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_cand;
      end
    end
  end

  assign w_cnt_inc = lock_cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ctrl_d      = ctrl_q;
    rdata_d     = rdata_q;
    lock_held_d = lock_held_q;
    lock_cnt_d  = lock_cnt_q;
    wfirst_d    = wfirst_q;
    case (state_q)
      S_IDLE: begin
        if (w_lock_rel) begin
          lock_held_d = 1'b0;
          lock_cnt_d  = '0;
        end
        if (w_pick_vld) begin
          gidx_d  = w_pick_idx;
          grant_d = ONE << w_pick_idx;
          we_d    = i_we[w_pick_idx];
          addr_d  = w_addr[w_pick_idx];
          wdata_d = w_wdata[w_pick_idx];
          ctrl_d  = w_ctrl[w_pick_idx];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wfirst_d = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        wfirst_d = 1'b0;
        // Busy is only raised one cycle after the strobe, so the first WAIT cycle is blind.
        if (!wfirst_q && !i_mc_busy) begin
          rdata_d = i_mc_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_d  = gidx_q;
        grant_d = '0;
        state_d = S_IDLE;
        if (|(i_lock & grant_q)) begin
          if (w_cnt_inc == LOCK_LIM) begin
            lock_held_d = 1'b0;
            lock_cnt_d  = '0;
          end else begin
            lock_held_d = 1'b1;
            lock_cnt_d  = w_cnt_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      last_q      <= LAST_RST;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ctrl_q      <= '0;
      rdata_q     <= '0;
      lock_held_q <= 1'b0;
      lock_cnt_q  <= '0;
      wfirst_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ctrl_q      <= ctrl_d;
      rdata_q     <= rdata_d;
      lock_held_q <= lock_held_d;
      lock_cnt_q  <= lock_cnt_d;
      wfirst_q    <= wfirst_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_done     = (state_q == S_DONE) ? grant_q : '0;
  assign o_stall    = i_req & ~o_done;
  assign o_rdata    = rdata_q;
  assign o_mc_req   = (state_q == S_ISSUE);
  assign o_mc_we    = we_q;
  assign o_mc_addr  = addr_q;
  assign o_mc_wdata = wdata_q;
  assign o_mc_ctrl  = ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_hart_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_hart_mem_arbiter -- directed scenarios plus random traffic against a
// transaction-level reference model of the arbiter.                Rev 1.0
// ============================================================================
module tb_hart_mem_arbiter;
  localparam int NHART    = 2;
  localparam int LOCK_MAX = 4;

  logic                CLK        = 1'b0;
  logic                RST_X      = 1'b1;
  logic [NHART-1:0]    i_req      = '0;
  logic [NHART-1:0]    i_lock     = '0;
  logic [NHART-1:0]    i_we       = '0;
  logic [32*NHART-1:0] i_addr     = '0;
  logic [32*NHART-1:0] i_wdata    = '0;
  logic [3*NHART-1:0]  i_ctrl     = '0;
  logic                i_mc_busy  = 1'b0;
  logic [127:0]        i_mc_rdata = '0;
  logic [NHART-1:0]    o_grant, o_done, o_stall;
  logic [127:0]        o_rdata;
  logic                o_mc_req, o_mc_we;
  logic [31:0]         o_mc_addr, o_mc_wdata;
  logic [2:0]          o_mc_ctrl;

  hart_mem_arbiter #(.NHART(NHART), .LOCK_MAX(LOCK_MAX)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .i_req(i_req), .i_lock(i_lock), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_ctrl(i_ctrl),
    .o_grant(o_grant), .o_done(o_done), .o_stall(o_stall), .o_rdata(o_rdata),
    .o_mc_req(o_mc_req), .o_mc_we(o_mc_we), .o_mc_addr(o_mc_addr),
    .o_mc_wdata(o_mc_wdata), .o_mc_ctrl(o_mc_ctrl),
    .i_mc_busy(i_mc_busy), .i_mc_rdata(i_mc_rdata)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: one transaction in flight, picked at edge m_p, DONE edge m_D.
  bit           m_inflight;
  int           m_g, m_p, m_D, m_lat;
  bit           m_held;
  int           m_cnt, m_last;
  logic         m_we;
  logic [31:0]  m_addr, m_wdata;
  logic [2:0]   m_ctrl;
  logic [127:0] m_rdata;
  int           lat_sel  = 1;
  int           busy_cnt = 0;

  int           gq[$];
  int           req_cyc, done_cyc, n_done;
  logic [NHART-1:0] done_mask;
  logic [127:0] last_rd_pre;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_inflight = 1'b0;
    m_held     = 1'b0;
    m_cnt      = 0;
    m_last     = NHART - 1;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_ctrl     = '0;
    m_rdata    = '0;
    busy_cnt   = 0;
  endfunction

  function automatic void model_edge();
    int pick;
    pick = -1;
    if (m_inflight && cyc == m_D - 1) m_rdata = i_mc_rdata;
    if (m_inflight && cyc == m_D) begin
      if (i_lock[m_g]) begin
        m_cnt++;
        if (m_cnt == LOCK_MAX) begin
          m_held = 1'b0;
          m_cnt  = 0;
        end else begin
          m_held = 1'b1;
        end
      end
      m_last     = m_g;
      m_inflight = 1'b0;
    end else if (!m_inflight) begin
      if (m_held && !i_lock[m_last]) begin
        m_held = 1'b0;
        m_cnt  = 0;
      end
      if (m_held) begin
        if (i_req[m_last]) pick = m_last;
      end else begin
        for (int off = 1; off <= NHART; off++)
          if (pick < 0 && i_req[(m_last + off) % NHART]) pick = (m_last + off) % NHART;
      end
      if (pick >= 0) begin
        m_inflight = 1'b1;
        m_g        = pick;
        m_p        = cyc;
        m_lat      = lat_sel;
        m_D        = cyc + 3 + ((lat_sel > 1) ? lat_sel : 1);
        m_we       = i_we[pick];
        m_addr     = i_addr[pick*32 +: 32];
        m_wdata    = i_wdata[pick*32 +: 32];
        m_ctrl     = i_ctrl[pick*3 +: 3];
      end
    end
  endfunction

  task automatic check_cycle();
    logic [NHART-1:0] eg, ed;
    eg = '0;
    ed = '0;
    if (m_inflight && cyc >= m_p && cyc <= m_D - 1) eg[m_g] = 1'b1;
    if (m_inflight && cyc == m_D - 1) ed[m_g] = 1'b1;
    chk("grant",    o_grant,    eg);
    chk("done",     o_done,     ed);
    chk("stall",    o_stall,    i_req & ~ed);
    chk("mc_req",   o_mc_req,   m_inflight && cyc == m_p);
    chk("mc_we",    o_mc_we,    m_we);
    chk("mc_addr",  o_mc_addr,  m_addr);
    chk("mc_wdata", o_mc_wdata, m_wdata);
    chk("mc_ctrl",  o_mc_ctrl,  m_ctrl);
    chk("rdata",    o_rdata,    m_rdata);
  endtask

  function automatic int gidx(input logic [NHART-1:0] v);
    int r;
    r = -1;
    for (int h = 0; h < NHART; h++) if (v[h]) r = h;
    return r;
  endfunction

  // One clock: model sees the pre-edge inputs, memory controller responds after the edge.
  task automatic tick();
    logic req_pre;
    req_pre     = o_mc_req;
    last_rd_pre = i_mc_rdata;
    @(posedge CLK);
    cyc++;
    if (RST_X) model_edge();
    #1;
    if (!RST_X)          busy_cnt = 0;
    else if (req_pre)    busy_cnt = m_lat;
    else if (busy_cnt > 0) busy_cnt--;
    i_mc_busy  = (busy_cnt != 0);
    i_mc_rdata = {$urandom, $urandom, $urandom, $urandom};
    check_cycle();
    if (o_mc_req) begin
      gq.push_back(gidx(o_grant));
      req_cyc = cyc;
    end
    if (o_done != '0) begin
      n_done++;
      done_cyc  = cyc;
      done_mask = o_done;
    end
  endtask

  task automatic set_cmd(input int h, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] c);
    i_we[h]            = we;
    i_addr[h*32 +: 32] = a;
    i_wdata[h*32 +: 32] = d;
    i_ctrl[h*3 +: 3]   = c;
  endtask

  task automatic run_until_grants(input int n, input string tag);
    int guard;
    guard = 0;
    while (gq.size() < n && guard < 200) begin
      tick();
      guard++;
    end
    chk({tag, "_grant_timeout"}, gq.size() >= n, 1'b1);
  endtask

  task automatic run_until_done(input string tag);
    int n0, guard;
    n0    = n_done;
    guard = 0;
    while (n_done == n0 && guard < 200) begin
      tick();
      guard++;
    end
    chk({tag, "_done_timeout"}, n_done > n0, 1'b1);
  endtask

  task automatic drain();
    int guard;
    i_req  = '0;
    i_lock = '0;
    guard  = 0;
    while (m_inflight && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n0;
    model_reset();
    #2;
    RST_X = 1'b0;
    #1;
    chk("rst_grant",   o_grant,   '0);
    chk("rst_done",    o_done,    '0);
    chk("rst_mc_req",  o_mc_req,  1'b0);
    chk("rst_mc_addr", o_mc_addr, '0);
    chk("rst_rdata",   o_rdata,   '0);
    repeat (3) tick();
    RST_X = 1'b1;
    tick();

    // Single read from hart0, busy for three cycles.
    set_cmd(0, 1'b0, 32'h8000_0000, 32'h0, 3'b011);
    lat_sel = 3;
    i_req   = 2'b01;
    k       = cyc + 1;
    gq.delete();
    run_until_done("req024");
    chk("req024_mcreq_edge", req_cyc,  k);
    chk("req024_done_edge",  done_cyc, k + 5);
    chk("req024_done_hart",  done_mask, 2'b01);
    chk("req024_rdata",      o_rdata,  last_rd_pre);
    drain();

    // Write from hart1; command fields visible from ISSUE through DONE.
    set_cmd(1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 3'b010);
    lat_sel = 2;
    i_req   = 2'b10;
    gq.delete();
    run_until_grants(1, "req029");
    chk("req029_issue_we",    o_mc_we,    1'b1);
    chk("req029_issue_addr",  o_mc_addr,  32'h0000_1000);
    chk("req029_issue_wdata", o_mc_wdata, 32'hDEAD_BEEF);
    chk("req029_issue_ctrl",  o_mc_ctrl,  3'b010);
    run_until_done("req029");
    chk("req029_done_we",    o_mc_we,    1'b1);
    chk("req029_done_addr",  o_mc_addr,  32'h0000_1000);
    chk("req029_done_wdata", o_mc_wdata, 32'hDEAD_BEEF);
    chk("req029_done_ctrl",  o_mc_ctrl,  3'b010);
    drain();

    // Both harts request continuously: strict alternation.
    set_cmd(0, 1'b0, 32'h0000_0100, 32'h1111_1111, 3'b001);
    lat_sel = 1;
    i_req   = 2'b11;
    gq.delete();
    run_until_grants(4, "req025");
    chk("req025_g0", gq[0], 0);
    chk("req025_g1", gq[1], 1);
    chk("req025_g2", gq[2], 0);
    chk("req025_g3", gq[3], 1);
    drain();

    // Hart1 holds lock: LOCK_MAX back-to-back grants, then hart0 gets a turn.
    i_lock = 2'b10;
    i_req  = 2'b11;
    gq.delete();
    run_until_grants(7, "req026");
    chk("req026_g0", gq[0], 0);
    for (int i = 1; i <= 4; i++) chk("req026_locked", gq[i], 1);
    chk("req026_g5", gq[5], 0);
    chk("req026_g6", gq[6], 1);
    drain();

    // Hart0 drops its request mid-transaction; completion still reported.
    lat_sel = 2;
    i_req   = 2'b01;
    gq.delete();
    run_until_grants(1, "req027");
    tick();
    i_req = 2'b10;
    run_until_done("req027");
    chk("req027_done_hart", done_mask, 2'b01);
    run_until_grants(2, "req027b");
    chk("req027_next_hart", gq[1], 1);
    drain();

    // Asynchronous reset in the middle of WAIT.
    set_cmd(0, 1'b1, 32'hA5A5_0000, 32'h5A5A_5A5A, 3'b111);
    lat_sel = 4;
    i_req   = 2'b01;
    gq.delete();
    run_until_grants(1, "req028");
    tick();
    n0 = n_done;
    #2;
    RST_X = 1'b0;
    model_reset();
    i_mc_busy = 1'b0;
    #1;
    chk("req028_grant",  o_grant,   '0);
    chk("req028_done",   o_done,    '0);
    chk("req028_mc_req", o_mc_req,  1'b0);
    chk("req028_mc_we",  o_mc_we,   1'b0);
    chk("req028_addr",   o_mc_addr, '0);
    chk("req028_rdata",  o_rdata,   '0);
    repeat (3) tick();
    chk("req028_no_done", n_done, n0);
    RST_X = 1'b1;
    i_req = 2'b11;
    gq.delete();
    run_until_grants(1, "req028b");
    chk("req028_first_hart", gq[0], 0);
    drain();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      i_req  = NHART'($urandom);
      i_lock = NHART'($urandom & $urandom & $urandom);
      for (int h = 0; h < NHART; h++)
        set_cmd(h, 1'($urandom), $urandom, $urandom, 3'($urandom));
      lat_sel = $urandom_range(1, 4);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
